// File: rtl/rf_write_arbiter_if.sv
// Bundle of the two requester write handshakes, the registered register-file write port
// and, when RFARB_FWD_EN is defined, the forwarding lookup ports.
interface rf_write_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_wsel;
    logic [31:0] req0_wdat;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_wsel;
    logic [31:0] req1_wdat;
    logic        req1_ready;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
`ifdef RFARB_FWD_EN
    logic [4:0]  lk_rsel1, lk_rsel2;
    logic        lk_hit1, lk_hit2;
    logic [31:0] lk_dat1, lk_dat2;

    modport master (
        output req0_valid, req0_wsel, req0_wdat, req1_valid, req1_wsel, req1_wdat,
        output lk_rsel1, lk_rsel2,
        input  req0_ready, req1_ready, rf_WEN, rf_wsel, rf_wdat,
        input  lk_hit1, lk_hit2, lk_dat1, lk_dat2
    );
    modport slave (
        input  req0_valid, req0_wsel, req0_wdat, req1_valid, req1_wsel, req1_wdat,
        input  lk_rsel1, lk_rsel2,
        output req0_ready, req1_ready, rf_WEN, rf_wsel, rf_wdat,
        output lk_hit1, lk_hit2, lk_dat1, lk_dat2
    );
`else
    modport master (
        output req0_valid, req0_wsel, req0_wdat, req1_valid, req1_wsel, req1_wdat,
        input  req0_ready, req1_ready, rf_WEN, rf_wsel, rf_wdat
    );
    modport slave (
        input  req0_valid, req0_wsel, req0_wdat, req1_valid, req1_wsel, req1_wdat,
        output req0_ready, req1_ready, rf_WEN, rf_wsel, rf_wdat
    );
`endif
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: one-entry slot per requester, one drain per cycle
// into a registered write port. Define RFARB_FWD_EN to add the pending-write forwarding lookup.
module rf_write_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic              CLK,
    input logic              nRST,
    rf_write_arbiter_if.slave bus
);
    typedef struct packed {
        logic        full;
        logic [4:0]  wsel;
        logic [31:0] wdat;
    } slot_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    slot_t       slot_q [2];
    slot_t       slot_d [2];
    slot_t       req    [2];
    slot_t       drain_slot;
    logic        age_q, age_d;          // index of the more recently filled slot
    logic [3:0]  wait_q, wait_d;
    logic        rf_wen_q, rf_wen_d;
    logic [4:0]  rf_wsel_q, rf_wsel_d;
    logic [31:0] rf_wdat_q, rf_wdat_d;
    logic [1:0]  drain, ready, valid, accept;

    assign req[0] = '{full: 1'b1, wsel: bus.req0_wsel, wdat: bus.req0_wdat};
    assign req[1] = '{full: 1'b1, wsel: bus.req1_wsel, wdat: bus.req1_wdat};
    assign valid  = {bus.req1_valid, bus.req0_valid};

    // Same-register hazard wins over starvation so that writes to one register stay in order.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        drain = 2'b00;
        if (slot_q[0].full && slot_q[1].full && slot_q[0].wsel == slot_q[1].wsel)
            drain = age_q ? 2'b01 : 2'b10;
        else if (slot_q[1].full && wait_q >= STARVE_LIM)
            drain = 2'b10;
        else if (slot_q[0].full)
            drain = 2'b01;
        else if (slot_q[1].full)
            drain = 2'b10;
    end

    assign ready  = ~{slot_q[1].full, slot_q[0].full} | drain;
    assign accept = valid & ready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_d[i] = slot_q[i];
            if (accept[i])
                slot_d[i] = req[i];
            else if (drain[i])
                slot_d[i].full = 1'b0;
        end

        case (accept)
            2'b01:   age_d = 1'b0;
            2'b10,
            2'b11:   age_d = 1'b1;
            default: age_d = age_q;
        endcase

        if (!slot_q[1].full || drain[1])
            wait_d = 4'd0;
        else if (wait_q != 4'hF)
            wait_d = wait_q + 4'd1;
        else
            wait_d = wait_q;

        // Register 0 writes are consumed but never reach the register file.
        drain_slot = drain[1] ? slot_q[1] : slot_q[0];
        rf_wen_d   = (drain != 2'b00) && (drain_slot.wsel != 5'd0);
        rf_wsel_d  = (drain != 2'b00) ? drain_slot.wsel : rf_wsel_q;
        rf_wdat_d  = (drain != 2'b00) ? drain_slot.wdat : rf_wdat_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: slot payloads are reset along with the full bits; a handful of flops, and
            // it keeps the lookup outputs and waveforms free of X after reset.
            for (int i = 0; i < 2; i++) slot_q[i] <= '0;
            age_q     <= 1'b0;
            wait_q    <= 4'd0;
            rf_wen_q  <= 1'b0;
            rf_wsel_q <= 5'd0;
            rf_wdat_q <= 32'd0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            for (int i = 0; i < 2; i++) slot_q[i] <= slot_d[i];
            age_q     <= age_d;
            wait_q    <= wait_d;
            rf_wen_q  <= rf_wen_d;
            rf_wsel_q <= rf_wsel_d;
            rf_wdat_q <= rf_wdat_d;
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.rf_WEN     = rf_wen_q;
    assign bus.rf_wsel    = rf_wsel_q;
    assign bus.rf_wdat    = rf_wdat_q;

`ifdef RFARB_FWD_EN
    // The output register is not searched: it commits on the falling edge before any reader.
    function automatic logic [32:0] lookup(input logic [4:0] rsel, input slot_t s0,
                                           input slot_t s1, input logic age);
        logic hit0, hit1;
        hit0 = s0.full && s0.wsel == rsel && rsel != 5'd0;
        hit1 = s1.full && s1.wsel == rsel && rsel != 5'd0;
        if (hit0 && hit1)
            return {1'b1, age ? s1.wdat : s0.wdat};
        else if (hit1)
            return {1'b1, s1.wdat};
        else if (hit0)
            return {1'b1, s0.wdat};
        return 33'd0;
    endfunction

    assign {bus.lk_hit1, bus.lk_dat1} = lookup(bus.lk_rsel1, slot_q[0], slot_q[1], age_q);
    assign {bus.lk_hit2, bus.lk_dat2} = lookup(bus.lk_rsel2, slot_q[0], slot_q[1], age_q);
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a falling-edge register-file model.
// Forwarding vectors are included when RFARB_FWD_EN is defined.
module tb_rf_write_arbiter;
    logic CLK = 1'b0;
    logic nRST;
    logic clr;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] regs [32];

    always #5 CLK = ~CLK;

    rf_write_arbiter_if bus ();
    rf_write_arbiter #(.STARVE_MAX(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always @(negedge CLK) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (bus.rf_WEN) begin
            regs[bus.rf_wsel] <= bus.rf_wdat;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] s0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] s1, input logic [31:0] d1);
        bus.req0_valid = v0; bus.req0_wsel = s0; bus.req0_wdat = d0;
        bus.req1_valid = v1; bus.req1_wsel = s1; bus.req1_wdat = d1;
    endtask

    // Starvation run expectations, sampled before each of edges 1..11.
    logic exp_r0 [11] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic exp_r1 [11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int   exp_rf [11] = '{0, 0, 1, 1, 1, 1, 2, 1, 1, 1, 1};

    initial begin
        nRST = 1'b0;
        clr  = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
`ifdef RFARB_FWD_EN
        bus.lk_rsel1 = 5'd3;
        bus.lk_rsel2 = 5'd5;
`endif
        #2;
        check("rst_ready0", 32'(bus.req0_ready), 32'd1);
        check("rst_ready1", 32'(bus.req1_ready), 32'd1);
        check("rst_wen",    32'(bus.rf_WEN),     32'd0);
        check("rst_wsel",   32'(bus.rf_wsel),    32'd0);
        check("rst_wdat",   bus.rf_wdat,         32'd0);
`ifdef RFARB_FWD_EN
        check("rst_hit1",   32'(bus.lk_hit1),    32'd0);
        check("rst_hit2",   32'(bus.lk_hit2),    32'd0);
`endif
        tick();
        tick();
        clr  = 1'b0;
        nRST = 1'b1;

        // Single write: accepted at edge k, on the port from k+1 to k+2.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("single_wen_k", 32'(bus.rf_WEN), 32'd0);
        tick();
        check("single_wen",  32'(bus.rf_WEN),  32'd1);
        check("single_wsel", 32'(bus.rf_wsel), 32'd5);
        check("single_wdat", bus.rf_wdat,      32'hDEADBEEF);
        tick();
        check("single_wen_off", 32'(bus.rf_WEN), 32'd0);
        check("single_reg5",    regs[5],         32'hDEADBEEF);

        // Register 0 write is acknowledged and dropped.
        drive(0, 0, 0, 1, 0, 32'h1234);
        check("r0_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("r0_wen",    32'(bus.rf_WEN),     32'd0);
        check("r0_empty1", 32'(bus.req1_ready), 32'd1);
        tick();
        check("r0_wen2",   32'(bus.rf_WEN),     32'd0);
        check("r0_reg0",   regs[0],             32'd0);

        // Same-register ordering: requester 1 is the younger same-edge write.
        drive(1, 7, 32'hA, 1, 7, 32'hB);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("ord_ready0", 32'(bus.req0_ready), 32'd1);
        check("ord_ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        check("ord_first_wen",  32'(bus.rf_WEN), 32'd1);
        check("ord_first_wdat", bus.rf_wdat,     32'hA);
        tick();
        check("ord_second_wen",  32'(bus.rf_WEN), 32'd1);
        check("ord_second_wdat", bus.rf_wdat,     32'hB);
        tick();
        check("ord_reg7", regs[7], 32'hB);

`ifdef RFARB_FWD_EN
        bus.lk_rsel1 = 5'd3;
        bus.lk_rsel2 = 5'd0;
        drive(1, 3, 32'h66, 1, 3, 32'h77);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("fwd_hit1", 32'(bus.lk_hit1), 32'd1);
        check("fwd_dat1", bus.lk_dat1,      32'h77);
        check("fwd_hit2", 32'(bus.lk_hit2), 32'd0);
        tick();
        check("fwd_hit1_one", 32'(bus.lk_hit1), 32'd1);
        check("fwd_dat1_one", bus.lk_dat1,      32'h77);
        tick();
        check("fwd_hit1_none", 32'(bus.lk_hit1), 32'd0);
        tick();
        tick();
`endif

        // Starvation override: both requesters valid every cycle.
        drive(1, 1, 32'h100, 1, 2, 32'h200);
        for (int c = 0; c < 11; c++) begin
            check($sformatf("starve_ready0_c%0d", c + 1), 32'(bus.req0_ready), 32'(exp_r0[c]));
            check($sformatf("starve_ready1_c%0d", c + 1), 32'(bus.req1_ready), 32'(exp_r1[c]));
            check($sformatf("starve_rf_c%0d", c + 1),
                  bus.rf_WEN ? 32'(bus.rf_wsel) : 32'd0, 32'(exp_rf[c]));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        check("starve_drained_wen", 32'(bus.rf_WEN), 32'd0);

        // Asynchronous reset with both slots full and a write on the port.
        drive(1, 9, 32'h99, 1, 10, 32'hAA);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("rstmid_pre_wen", 32'(bus.rf_WEN), 32'd1);
        nRST = 1'b0;
        #1;
        check("rstmid_wen",    32'(bus.rf_WEN),     32'd0);
        check("rstmid_ready0", 32'(bus.req0_ready), 32'd1);
        check("rstmid_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        tick();
        nRST = 1'b1;
        tick();
        tick();
        check("rstmid_reg9",    regs[9],         32'd0);
        check("rstmid_reg10",   regs[10],        32'd0);
        check("rstmid_post_wen", 32'(bus.rf_WEN), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
